// File: rtl/alu_flag_stage.sv
// Two-stage result/flag pipeline behind the ALU: registers the result, derives Z/N, and keeps NZCV.
// Optional macro V_STICKY_EN makes flag_v sticky until cleared via clr_sticky.
module alu_flag_stage #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic             in_setflags,
  input  logic             clr_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_negative,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int NGRP = WIDTH / GROUP;

  generate
    if ((WIDTH % GROUP) != 0) begin : g_width_check
      $error("alu_flag_stage: WIDTH must be a multiple of GROUP");
    end
  endgenerate

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_result;
  logic             r_s1_carry;
  logic             r_s1_overflow;
  logic             r_s1_setflags;
  logic [NGRP-1:0]  r_s1_gz;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_zero;
  logic             r_out_negative;
  logic             r_out_carry;
  logic             r_out_overflow;
  logic             r_s2_setflags;

  logic             r_flag_n;
  logic             r_flag_z;
  logic             r_flag_c;
  logic             r_flag_v;

  logic [NGRP-1:0]  w_gz;
  logic             w_s2_free;
  logic             w_s1_adv;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_flag_upd;

  // Per-group zero detect; the wide AND is deferred to stage 2 to keep stage 1 shallow.
  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_zero_grp
      assign w_gz[gi] = ~|in_result[gi*GROUP +: GROUP];
    end
  endgenerate

  assign w_s2_free  = !r_s2_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign in_ready   = !r_s1_valid || w_s1_adv;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_s2_valid && out_ready;
  assign w_flag_upd = w_out_xfer && r_s2_setflags;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_result   <= '0;
      r_s1_carry    <= 1'b0;
      r_s1_overflow <= 1'b0;
      r_s1_setflags <= 1'b0;
      r_s1_gz       <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid    <= 1'b1;
      r_s1_result   <= in_result;
      r_s1_carry    <= in_carry;
      r_s1_overflow <= in_overflow;
      r_s1_setflags <= in_setflags;
      r_s1_gz       <= w_gz;
    end else if (w_s1_adv) begin
      r_s1_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid     <= 1'b0;
      r_out_result   <= '0;
      r_out_zero     <= 1'b0;
      r_out_negative <= 1'b0;
      r_out_carry    <= 1'b0;
      r_out_overflow <= 1'b0;
      r_s2_setflags  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid     <= 1'b1;
      r_out_result   <= r_s1_result;
      r_out_zero     <= &r_s1_gz;
      r_out_negative <= r_s1_result[WIDTH-1];
      r_out_carry    <= r_s1_carry;
      r_out_overflow <= r_s1_overflow;
      r_s2_setflags  <= r_s1_setflags;
    end else if (w_out_xfer) begin
      r_s2_valid     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else if (w_flag_upd) begin
      r_flag_n <= r_out_negative;
      r_flag_z <= r_out_zero;
      r_flag_c <= r_out_carry;
    end
  end

`ifdef V_STICKY_EN
  // A set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flag_v <= 1'b0;
    end else if (w_flag_upd && r_out_overflow) begin
      r_flag_v <= 1'b1;
    end else if (clr_sticky) begin
      r_flag_v <= 1'b0;
    end
  end
`else
  logic w_unused_clr_sticky;
  assign w_unused_clr_sticky = clr_sticky;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flag_v <= 1'b0;
    end else if (w_flag_upd) begin
      r_flag_v <= r_out_overflow;
    end
  end
`endif

  assign out_valid    = r_s2_valid;
  assign out_result   = r_out_result;
  assign out_zero     = r_out_zero;
  assign out_negative = r_out_negative;
  assign out_carry    = r_out_carry;
  assign out_overflow = r_out_overflow;
  assign flag_n       = r_flag_n;
  assign flag_z       = r_flag_z;
  assign flag_c       = r_flag_c;
  assign flag_v       = r_flag_v;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Bench for alu_flag_stage: queue-based occupancy/age model checked every cycle plus directed literal checks.
module tb_alu_flag_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic        in_carry = 1'b0;
  logic        in_overflow = 1'b0;
  logic        in_setflags = 1'b0;
  logic        clr_sticky = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero, out_negative, out_carry, out_overflow;
  logic        flag_n, flag_z, flag_c, flag_v;

  alu_flag_stage #(.WIDTH(32), .GROUP(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_carry(in_carry), .in_overflow(in_overflow), .in_setflags(in_setflags),
    .clr_sticky(clr_sticky),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_negative(out_negative), .out_carry(out_carry),
    .out_overflow(out_overflow),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        sf;
    int          stamp;
  } entry_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int          cyc;
  } log_t;

  entry_t mq[$];
  log_t   lq[$];
  logic [3:0] mflags = 4'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: pipeline contents are the accepted-but-undelivered entries in order; the head is
  // presented once two edges have passed since its acceptance; only a full pipe with a
  // stalled consumer refuses input.
  always @(negedge clk) begin
    logic exp_ready, exp_valid, set_v;
    entry_t h;
    cyc++;
    if (!reset_n) begin
      mq.delete();
      mflags = 4'b0;
    end else begin
      exp_ready = !(mq.size() == 2 && !out_ready);
      exp_valid = (mq.size() > 0) && (cyc - mq[0].stamp >= 2);
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        h = mq[0];
        chk("out_result", out_result, h.res);
        chk("out_flags", {28'b0, out_negative, out_zero, out_carry, out_overflow},
            {28'b0, h.res[31], (h.res == 32'b0), h.c, h.v});
      end
      chk("flag_reg", {28'b0, flag_n, flag_z, flag_c, flag_v}, {28'b0, mflags});
      set_v = 1'b0;
      if (exp_valid && out_ready) begin
        h = mq.pop_front();
        lq.push_back('{res: out_result, zero: out_zero, cyc: cyc});
        $display("out: result=0x%08h zero=%0b neg=%0b c=%0b v=%0b sf=%0b", out_result,
                 out_zero, out_negative, out_carry, out_overflow, h.sf);
        if (h.sf) begin
          mflags[3:1] = {h.res[31], (h.res == 32'b0), h.c};
`ifdef V_STICKY_EN
          if (h.v) begin
            mflags[0] = 1'b1;
            set_v = 1'b1;
          end
`else
          mflags[0] = h.v;
`endif
        end
      end
`ifdef V_STICKY_EN
      if (!set_v && clr_sticky) mflags[0] = 1'b0;
`endif
      if (in_valid && exp_ready)
        mq.push_back('{res: in_result, c: in_carry, v: in_overflow, sf: in_setflags, stamp: cyc});
    end
  end

  task automatic send(input logic [31:0] r, input logic c, input logic v, input logic sf);
    int guard;
    logic acc;
    in_valid = 1'b1; in_result = r; in_carry = c; in_overflow = v; in_setflags = sf;
    guard = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 50);
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no accept after %0d cycles, required accept of 0x%08h", guard, r);
    end
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1);
  end

  initial begin
    logic anyzero;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_flags", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Zero detect
    out_ready = 1'b1;
    lq.delete();
    send(32'h0000_0000, 1'b0, 1'b0, 1'b1);
    send(32'h0001_0000, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 1'b0, 1'b0, 1'b1);
    idle_cycles(4);
    chk("zd_count", lq.size(), 32'd3);
    if (lq.size() == 3)
      chk("zd_zeros", {29'b0, lq[0].zero, lq[1].zero, lq[2].zero}, 32'b100);
    chk("zd_flag_z", {31'b0, flag_z}, 32'd0);
    chk("zd_flag_n", {31'b0, flag_n}, 32'd1);

    // Stall with both stages full
    out_ready = 1'b0;
    lq.delete();
    send(32'h0000_0005, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0000, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_result", out_result, 32'h5);
      chk("stall_flags", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'b1000);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle_cycles(4);
    chk("stall_count", lq.size(), 32'd2);
    if (lq.size() == 2) begin
      chk("stall_order0", lq[0].res, 32'h5);
      chk("stall_order1", lq[1].res, 32'h0);
    end

    // Setflags gating
    send(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    send(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    idle_cycles(4);
    chk("sf_flags", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'b1010);

    // Throughput: walking ones back to back
    lq.delete();
    for (int i = 0; i < 32; i++) send(32'h1 << i, 1'b0, 1'b0, 1'b0);
    idle_cycles(4);
    chk("tput_count", lq.size(), 32'd32);
    if (lq.size() == 32) begin
      chk("tput_span", lq[31].cyc - lq[0].cyc, 32'd31);
      anyzero = 1'b0;
      foreach (lq[i]) anyzero = anyzero | lq[i].zero;
      chk("tput_zero", {31'b0, anyzero}, 32'd0);
      chk("tput_last", lq[31].res, 32'h8000_0000);
    end

`ifdef V_STICKY_EN
    send(32'h0000_0001, 1'b0, 1'b1, 1'b1);
    send(32'h0000_0002, 1'b0, 1'b0, 1'b1);
    idle_cycles(4);
    chk("sticky_hold", {31'b0, flag_v}, 32'd1);
    clr_sticky = 1'b1;
    idle_cycles(1);
    clr_sticky = 1'b0;
    idle_cycles(1);
    chk("sticky_clear", {31'b0, flag_v}, 32'd0);
    clr_sticky = 1'b1;
    send(32'h0000_0003, 1'b0, 1'b1, 1'b1);
    idle_cycles(2);
    clr_sticky = 1'b0;
    chk("sticky_set_wins", {31'b0, flag_v}, 32'd1);
    idle_cycles(2);
`endif

    // Reset mid-stream
    send(32'h8000_0001, 1'b1, 1'b0, 1'b1);
    send(32'h8000_0002, 1'b1, 1'b0, 1'b1);
    send(32'h8000_0003, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2;
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_flags", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    send(32'h0000_0000, 1'b0, 1'b1, 1'b1);
    idle_cycles(4);
    chk("post_rst_flags", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'b0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
